// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file write port between ALU and MEM writeback and tracks in-flight writes.
// Optional WB_ARB_FAIRNESS_EN: bounds MEM starvation to MAX_WAIT cycles under continuous ALU traffic.
module regfile_write_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [ADDR_W-1:0]        alu_rd,
    input  logic [DATA_W-1:0]        alu_data,
    output logic                     alu_ready,
    input  logic                     mem_valid,
    input  logic [ADDR_W-1:0]        mem_rd,
    input  logic [DATA_W-1:0]        mem_data,
    output logic                     mem_ready,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_rd,
    output logic                     rf_reg_write,
    output logic [ADDR_W-1:0]        rf_rd,
    output logic [DATA_W-1:0]        rf_write_data,
    output logic [(1<<ADDR_W)-1:0]   pending
);

    localparam int NREG = 1 << ADDR_W;

    if (MAX_WAIT < 1) begin : g_bad_max_wait
        $error("MAX_WAIT must be at least 1");
    end

    logic                 force_mem;
    logic                 xfer;
    logic [ADDR_W-1:0]    xfer_rd;
    logic [DATA_W-1:0]    xfer_data;
    logic [NREG-1:0]      pending_next;

`ifdef WB_ARB_FAIRNESS_EN
    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt;

    assign force_mem = (wait_cnt == WAIT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!mem_valid || mem_ready) begin
            wait_cnt <= '0;
        end else if (!force_mem) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign force_mem = 1'b0;
`endif

    // Readiness depends only on valids (and the starvation counter), never on request payload.
    assign alu_ready = !rst && alu_valid && !force_mem;
    assign mem_ready = !rst && mem_valid && (!alu_valid || force_mem);

    assign xfer      = alu_ready || mem_ready;
    assign xfer_rd   = alu_ready ? alu_rd   : mem_rd;
    assign xfer_data = alu_ready ? alu_data : mem_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_reg_write  <= 1'b0;
            rf_rd         <= '0;
            rf_write_data <= '0;
        end else begin
            rf_reg_write <= xfer && (xfer_rd != '0);
            if (xfer && (xfer_rd != '0)) begin
                rf_rd         <= xfer_rd;
                rf_write_data <= xfer_data;
            end
        end
    end

    // Clear before set so a newly issued producer survives a same-cycle retirement.
    always_comb begin
        pending_next = pending;
        if (xfer) begin
            pending_next[xfer_rd] = 1'b0;
        end
        if (issue_valid) begin
            pending_next[issue_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: reference model predicts grants, writes and pending bits.
module tb_regfile_write_arbiter;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int MAX_WAIT = 4;
`ifdef WB_ARB_FAIRNESS_EN
    localparam int EXP_FIRST_GRANT = MAX_WAIT + 1;
`else
    localparam int EXP_FIRST_GRANT = 0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              alu_valid = 1'b0;
    logic [ADDR_W-1:0] alu_rd = '0;
    logic [DATA_W-1:0] alu_data = '0;
    logic              alu_ready;
    logic              mem_valid = 1'b0;
    logic [ADDR_W-1:0] mem_rd = '0;
    logic [DATA_W-1:0] mem_data = '0;
    logic              mem_ready;
    logic              issue_valid = 1'b0;
    logic [ADDR_W-1:0] issue_rd = '0;
    logic              rf_reg_write;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_write_data;
    logic [31:0]       pending;

    regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rf_reg_write(rf_reg_write), .rf_rd(rf_rd), .rf_write_data(rf_write_data),
        .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] exp_pending = '0;
    int          starve = 0;
    bit          alu_acc = 1'b0;
    bit          mem_acc = 1'b0;
    bit          rst_edge = 1'b1;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: decides grants from the arbitration rules and queues the expected writes.
    always @(negedge clk) begin
        bit ar, mr, frc;
        frc = 1'b0;
`ifdef WB_ARB_FAIRNESS_EN
        frc = (starve >= MAX_WAIT);
`endif
        if (rst) begin
            ar = 1'b0;
            mr = 1'b0;
        end else if (frc) begin
            ar = 1'b0;
            mr = mem_valid;
        end else begin
            ar = alu_valid;
            mr = mem_valid && !alu_valid;
        end
        chk("alu_ready", 64'(alu_ready), 64'(ar));
        chk("mem_ready", 64'(mem_ready), 64'(mr));
        alu_acc  = ar;
        mem_acc  = mr;
        rst_edge = rst;
        if (rst) begin
            exp_q.delete();
            exp_pending = '0;
            starve = 0;
        end else begin
            if (ar && alu_rd != 0) exp_q.push_back('{alu_rd, alu_data});
            if (mr && mem_rd != 0) exp_q.push_back('{mem_rd, mem_data});
            if (ar) exp_pending[alu_rd] = 1'b0;
            if (mr) exp_pending[mem_rd] = 1'b0;
            if (issue_valid && issue_rd != 0) exp_pending[issue_rd] = 1'b1;
            if (!mem_valid || mr) starve = 0;
            else if (starve < MAX_WAIT) starve++;
        end
    end

    // Monitor: each edge either retires exactly the queued write or shows an idle write port.
    always @(posedge clk) begin
        wr_t w;
        #2;
        if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            chk("rf_reg_write", 64'(rf_reg_write), 64'(1));
            chk("rf_rd", 64'(rf_rd), 64'(w.rd));
            chk("rf_write_data", 64'(rf_write_data), 64'(w.data));
        end else begin
            chk("rf_reg_write_idle", 64'(rf_reg_write), 64'(0));
        end
        if (rst_edge) begin
            chk("rst_rf_rd", 64'(rf_rd), 64'(0));
            chk("rst_rf_write_data", 64'(rf_write_data), 64'(0));
        end
        chk("pending", 64'(pending), 64'(exp_pending));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid   = 1'b0;
        mem_valid   = 1'b0;
        issue_valid = 1'b0;
    endtask

    initial begin
        int first;
        int p_alu;

        // reset with every input active
        alu_valid = 1'b1; alu_rd = 5'd9;  alu_data = 32'h1234_5678;
        mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'h8765_4321;
        issue_valid = 1'b1; issue_rd = 5'd11;
        step();
        chk("rst_alu_ready", 64'(alu_ready), 64'(0));
        chk("rst_mem_ready", 64'(mem_ready), 64'(0));
        step();
        rst = 1'b0;
        idle();
        step();
        step();
        chk("post_rst_pending", 64'(pending), 64'(0));
        chk("post_rst_write", 64'(rf_reg_write), 64'(0));

        // single write
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
        #1 chk("single_alu_ready", 64'(alu_ready), 64'(1));
        step();
        idle();
        chk("single_we", 64'(rf_reg_write), 64'(1));
        chk("single_rd", 64'(rf_rd), 64'(5));
        chk("single_data", 64'(rf_write_data), 64'hDEAD_BEEF);
        step();
        chk("single_we_after", 64'(rf_reg_write), 64'(0));

        // conflict: ALU first, MEM next cycle
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h22;
        #1 chk("conflict_alu_ready", 64'(alu_ready), 64'(1));
        chk("conflict_mem_ready0", 64'(mem_ready), 64'(0));
        step();
        alu_valid = 1'b0;
        #1 chk("conflict_mem_ready1", 64'(mem_ready), 64'(1));
        chk("conflict_rd3", 64'(rf_rd), 64'(3));
        step();
        idle();
        chk("conflict_rd4", 64'(rf_rd), 64'(4));
        chk("conflict_data4", 64'(rf_write_data), 64'h22);
        step();

        // x0 sink
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hFFFF_FFFF;
        #1 chk("x0_mem_ready", 64'(mem_ready), 64'(1));
        step();
        idle();
        chk("x0_we", 64'(rf_reg_write), 64'(0));
        chk("x0_pending0", 64'(pending[0]), 64'(0));

        // scoreboard set/clear
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        idle();
        chk("sb_set7", 64'(pending[7]), 64'(1));
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        idle();
        chk("sb_set_wins7", 64'(pending[7]), 64'(1));
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h78;
        step();
        idle();
        chk("sb_clear7", 64'(pending[7]), 64'(0));
        step();

        // starvation / fairness window
        first = 0;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h100;
        mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 32'hC0DE;
        for (int k = 1; k <= 20; k++) begin
            #1;
            if (mem_ready && mem_valid && first == 0) first = k;
            step();
            if (first == k) mem_valid = 1'b0;
            if (alu_acc) begin
                alu_rd   = 5'($urandom_range(31, 1));
                alu_data = $urandom;
            end
        end
        chk("fairness_first_grant", 64'(first), 64'(EXP_FIRST_GRANT));
        idle();
        step();

        // randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            p_alu = ((i / 300) % 2 == 1) ? 95 : 50;
            if (!alu_valid || alu_acc) begin
                alu_valid = ($urandom_range(99) < p_alu);
                alu_rd    = 5'($urandom);
                alu_data  = $urandom;
            end
            if (!mem_valid || mem_acc) begin
                mem_valid = ($urandom_range(99) < 40);
                mem_rd    = 5'($urandom);
                mem_data  = $urandom;
            end
            issue_valid = ($urandom_range(99) < 30);
            issue_rd    = 5'($urandom);
            rst         = ($urandom_range(299) == 0);
            step();
        end
        rst = 1'b0;
        idle();
        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: the ALU pipeline (ALU) and the load/multi-cycle unit (MEM).
- Registers the granted write onto the register file's write port.
- Keeps a pending-write scoreboard so decode can detect RAW hazards on registers still in flight.
- Sits between the execute/memory stages and the register file.

Parameters:
DATA_W, 32, width of write data
ADDR_W, 5, register address width (2^ADDR_W registers)
MAX_WAIT, 4, cycles MEM may be stalled by ALU before forced grant (used only with fairness feature)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
alu_valid  input  1  ALU writeback request
alu_rd  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
alu_ready  output  1  ALU request accepted this cycle (combinational)
mem_valid  input  1  MEM writeback request
mem_rd  input  ADDR_W  MEM destination register
mem_data  input  DATA_W  MEM result
mem_ready  output  1  MEM request accepted this cycle (combinational)
issue_valid  input  1  decode issued an instruction that writes issue_rd
issue_rd  input  ADDR_W  destination of the issued instruction
rf_reg_write  output  1  register file write enable (registered)
rf_rd  output  ADDR_W  register file write address (registered)
rf_write_data  output  DATA_W  register file write data (registered)
pending  output  2^ADDR_W  scoreboard; bit i = 1 means register i has a write in flight

Behaviour:
- Reset (rst=1 at a clk edge):
  - rf_reg_write=0, rf_rd=0, rf_write_data=0, pending=0.
  - Fairness wait counter cleared.
  - While rst=1, alu_ready=0 and mem_ready=0.
- Handshake:
  - A transfer occurs when valid && ready in the same cycle.
  - A requester holds valid, rd and data stable until ready.
  - ready never depends on the requester's own data.
- Grant, default fixed priority, ALU highest:
  - alu_ready = alu_valid.
  - mem_ready = mem_valid && !alu_valid.
  - At most one transfer per cycle.
- Output register, 1-cycle latency:
  - A transfer at edge N drives rf_reg_write=1, rf_rd=rd and rf_write_data=data during cycle N+1.
  - With no transfer, rf_reg_write=0; rf_rd and rf_write_data hold their previous values.
  - A back-to-back transfer every cycle sustains one write per cycle.
- rd = 0:
  - The request is accepted normally (ready behaves as above).
  - rf_reg_write stays 0 for that slot; x0 is never written.
- Scoreboard:
  - issue_valid sets pending[issue_rd] at the edge, unless issue_rd=0.
  - A transfer clears pending[rd] at the same edge as the transfer, not one cycle later.
  - Set and clear of the same register in the same cycle: set wins (a new producer is in flight).
  - pending[0] is always 0.
  - Set and clear of different registers in the same cycle both take effect.
- Reset mid-operation:
  - An in-flight output write is dropped (rf_reg_write=0 the next cycle).
  - The scoreboard is cleared; requesters must re-present after reset.

Optional Feature:
Macro WB_ARB_FAIRNESS_EN.
- Defined:
  - A wait counter (width ceil(log2(MAX_WAIT+1))) increments each cycle mem_valid && !mem_ready, saturating at MAX_WAIT.
  - The counter clears on a MEM transfer or when mem_valid=0.
  - When the counter equals MAX_WAIT: mem_ready = mem_valid and alu_ready = 0 for that cycle. MEM wins; ALU stalls.
  - So MEM is stalled for at most MAX_WAIT consecutive cycles.
- Undefined:
  - Pure fixed priority, no counter logic.
  - MEM may starve indefinitely under continuous ALU traffic.

Test Plan:
- Reset: drive rst=1 for 2 cycles with all inputs active -> rf_reg_write=0, pending=0, alu_ready=mem_ready=0; after release all outputs stay 0 until a request is presented.
- Single write: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for one cycle -> alu_ready=1 that cycle; next cycle rf_reg_write=1, rf_rd=5, rf_write_data=0xDEADBEEF; the cycle after, rf_reg_write=0.
- Conflict: alu(rd=3, 0x11) and mem(rd=4, 0x22) both valid -> cycle 0 alu_ready=1, mem_ready=0; cycle 1 mem_ready=1; rf writes reg 3=0x11, then reg 4=0x22 on consecutive cycles.
- x0 sink: mem_valid=1, mem_rd=0, mem_data=0xFFFFFFFF -> mem_ready=1, rf_reg_write remains 0, pending[0]=0.
- Scoreboard: issue rd=7 -> pending[7]=1; later ALU transfer to rd=7 while issue_valid=1, issue_rd=7 in the same cycle -> pending[7] stays 1; a subsequent transfer to rd=7 with no issue -> pending[7]=0.
- Fairness (WB_ARB_FAIRNESS_EN, MAX_WAIT=4): continuous alu_valid plus mem_valid -> mem_ready=1 and alu_ready=0 on the 5th cycle; without the macro, mem_ready stays 0 for 20 cycles.
